fetch_stage: RTL

Instruction fetch front end that feeds the decode stage: holds the PC, issues one instruction-memory read at a time, and presents valid_o/pc_o/instruction_o to decode. Honours decode's stall output and redirects on taken branch/jump, squashing wrong-path fetches, including in-flight memory responses. Single-issue, at most one outstanding memory request.

---
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: single-issue instruction fetch front end.
//   Holds the next-fetch PC and issues one instruction-memory read at a time,
//   with at most one request outstanding. The returned instruction goes into a
//   single output slot that decode reads. The block honours decode stalls.
//   A taken branch or jump redirects fetch: the presented instruction and any
//   in-flight response are discarded as wrong-path.
//
// Optional build macro: FETCH_PERF_CNT_EN adds saturating performance counters.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   stall_i               decode does not consume the presented instruction
//   branch_taken_i/jump_i redirect requests; redirect_pc_i is the target
//   imem_req_o/addr_o     read request (combinational), accepted when asserted
//   imem_rvalid_i/rdata_i read response, one or more cycles after the request
//   valid_o/pc_o/instruction_o  registered instruction slot presented to decode
//   perf_*_o              (FETCH_PERF_CNT_EN only) fetched/squashed/stall counts
// -----------------------------------------------------------------------------
package params_pkg;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] instruction_t;
endpackage

module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     branch_taken_i,
    input  logic                     jump_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_WIDTH-1:0]    imem_addr_o,
    input  logic                     imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
    output logic                     valid_o,
    output logic [ADDR_WIDTH-1:0]    pc_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]              perf_fetched_o,
    output logic [31:0]              perf_squashed_o,
    output logic [31:0]              perf_stall_cycles_o,
`endif
    output params_pkg::instruction_t instruction_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_d;
    logic [ADDR_WIDTH-1:0]    r_pc;
    logic [ADDR_WIDTH-1:0]    w_pc_d;
    logic [ADDR_WIDTH-1:0]    r_req_pc;
    logic [ADDR_WIDTH-1:0]    w_req_pc_d;
    logic                     r_kill;
    logic                     w_kill_d;
    logic                     w_valid_d;
    logic [ADDR_WIDTH-1:0]    w_pc_o_d;
    params_pkg::instruction_t w_instr_d;
    logic                     w_redirect;
    logic                     w_req;
    logic                     w_fill;

    assign w_redirect  = branch_taken_i | jump_i;
    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_kill        <= 1'b0;
            valid_o       <= 1'b0;
            pc_o          <= RESET_PC;
            instruction_o <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_req_pc      <= w_req_pc_d;
            r_kill        <= w_kill_d;
            valid_o       <= w_valid_d;
            pc_o          <= w_pc_o_d;
            instruction_o <= w_instr_d;
        end
    end

    // Next-state, request issue, response fill/squash and redirect
    always_comb begin
        w_state_d  = r_state;
        w_pc_d     = r_pc;
        w_req_pc_d = r_req_pc;
        w_kill_d   = r_kill;
        w_valid_d  = valid_o;
        w_pc_o_d   = pc_o;
        w_instr_d  = instruction_o;
        w_fill     = 1'b0;

        // Only issue when the slot is empty or is being consumed this edge,
        // so a returning response always finds the slot free.
        w_req = rst_i && (r_state == IDLE) && !w_redirect && (!valid_o || !stall_i);

        if (valid_o && !stall_i) begin
            w_valid_d = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_d  = WAIT;
                    w_req_pc_d = r_pc;
                    w_pc_d     = r_pc + ADDR_WIDTH'(4);
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_d = IDLE;
                    w_kill_d  = 1'b0;
                    if (!r_kill && !w_redirect) begin
                        w_fill    = 1'b1;
                        w_valid_d = 1'b1;
                        w_pc_o_d  = r_req_pc;
                        w_instr_d = params_pkg::instruction_t'(imem_rdata_i);
                    end
                end else if (w_redirect) begin
                    // Response still owed: remember to discard it on arrival.
                    w_kill_d = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        if (w_redirect) begin
            w_pc_d    = redirect_pc_i;
            w_valid_d = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_drop;
    logic w_clear;

    assign w_drop  = (r_state == WAIT) && imem_rvalid_i && (r_kill || w_redirect);
    assign w_clear = w_redirect && valid_o;

    // Saturating event counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetched_o      <= 32'd0;
            perf_squashed_o     <= 32'd0;
            perf_stall_cycles_o <= 32'd0;
        end else begin
            if (w_fill && (perf_fetched_o != '1)) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if ((w_drop || w_clear) && (perf_squashed_o != '1)) begin
                perf_squashed_o <= perf_squashed_o + 32'd1;
            end
            if (valid_o && stall_i && (perf_stall_cycles_o != '1)) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule
